iram_param_ctrl: RTL and testbench

- Parametrised successor to the CoreABC 512x9 instruction RAM: DATA_WIDTH x DEPTH, built from 512-word banks.
- Adds an init loader with a streaming valid/ready handshake and auto-incrementing address.
- Adds a load checksum, an optional read pipeline stage, and out-of-range read flagging.
- Sits between the program-load path (boot loader or APB) and the CoreABC instruction fetch.

---
 rtl/iram_param_ctrl_pkg.sv | 9 +
 rtl/iram_param_ctrl_if.sv | 29 ++
 rtl/iram_param_ctrl_bank.sv | 20 ++
 rtl/iram_param_ctrl.sv | 95 +++++++++
 tb/tb_iram_param_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iram_param_ctrl_pkg.sv
// iram_pkg: bank geometry, loader FSM states and bank-count helper for iram_param_ctrl
package iram_pkg;
  localparam int BANK_DEPTH = 512;
  localparam int BANK_AW = 9;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  function automatic int nbanks(input int depth);
    return depth / BANK_DEPTH;
  endfunction
endpackage

// File: rtl/iram_param_ctrl_if.sv
// iram_param_ctrl_if: read port and init-loader stream bundle between loader/fetch side and the RAM
interface iram_param_ctrl_if #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH = 512
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  logic                  RENABLE;
  logic [ADDR_WIDTH-1:0] RADDR;
  logic [DATA_WIDTH-1:0] RD;
  logic                  RVALID;
  logic                  RERR;
  logic                  INIT_START;
  logic                  INIT_VALID;
  logic [DATA_WIDTH-1:0] INIT_DATA;
  logic                  INIT_LAST;
  logic                  INIT_READY;
  logic                  INIT_DONE;
  logic [ADDR_WIDTH:0]   INIT_COUNT;
  logic [DATA_WIDTH-1:0] INIT_CSUM;
  logic                  BUSY;
  modport master (
    output RENABLE, RADDR, INIT_START, INIT_VALID, INIT_DATA, INIT_LAST,
    input  RD, RVALID, RERR, INIT_READY, INIT_DONE, INIT_COUNT, INIT_CSUM, BUSY
  );
  modport slave (
    input  RENABLE, RADDR, INIT_START, INIT_VALID, INIT_DATA, INIT_LAST,
    output RD, RVALID, RERR, INIT_READY, INIT_DONE, INIT_COUNT, INIT_CSUM, BUSY
  );
endinterface

// File: rtl/iram_param_ctrl_bank.sv
// iram_bank: 512-word simple dual-port RAM bank, registered read that holds when re is low
module iram_bank
  import iram_pkg::*;
#(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BANK_AW-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [BANK_AW-1:0]    raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/iram_param_ctrl.sv
// iram_param_ctrl: banked instruction RAM with streaming init loader, load checksum and optional read pipe
module iram_param_ctrl
  import iram_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH = 512,
  parameter int PIPE = 0
) (
  input logic RWCLK,
  input logic RESET,
  iram_param_ctrl_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int NB = nbanks(DEPTH);
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  state_e state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic load, xfer, acc, oor;
  logic [ADDR_WIDTH-1:0] wa;
  logic [BW-1:0] wbank, rbank, bank1_q;
  logic v1_q, err1_q;
  logic [DATA_WIDTH-1:0] rdata [NB];
  logic [DATA_WIDTH-1:0] s1_data, hold_q;
  assign load = state_q == LOAD;
  assign bus.INIT_READY = load & ~bus.INIT_START;
  assign xfer = bus.INIT_VALID & bus.INIT_READY;
  assign wa = count_q[ADDR_WIDTH-1:0];
  assign wbank = BW'(wa >> BANK_AW);
  assign rbank = BW'(bus.RADDR >> BANK_AW);
  assign acc = bus.RENABLE & ~load;
  assign oor = {1'b0, bus.RADDR} >= (ADDR_WIDTH+1)'(DEPTH);
  // The DEPTH-th word forces DONE, so COUNT tops out at DEPTH and never wraps
  always_comb begin
    state_d = bus.INIT_START ? LOAD
            : (xfer && (bus.INIT_LAST || count_q == (ADDR_WIDTH+1)'(DEPTH - 1))) ? DONE
            : state_q;
    count_d = bus.INIT_START ? '0 : xfer ? count_q + 1'b1 : count_q;
    csum_d = bus.INIT_START ? '0 : xfer ? csum_q ^ bus.INIT_DATA : csum_q;
  end
  always_ff @(posedge RWCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      csum_q <= '0;
      v1_q <= 1'b0;
      err1_q <= 1'b0;
      bank1_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q <= csum_d;
      v1_q <= acc;
      err1_q <= acc & oor;
      if (acc) bank1_q <= rbank;
      if (v1_q) hold_q <= s1_data;
    end
  end
  for (genvar i = 0; i < NB; i++) begin : g_bank
    iram_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk  (RWCLK),
      .we   (xfer && wbank == BW'(i)),
      .waddr(wa[BANK_AW-1:0]),
      .wdata(bus.INIT_DATA),
      .re   (acc && !oor && rbank == BW'(i)),
      .raddr(bus.RADDR[BANK_AW-1:0]),
      .rdata(rdata[i])
    );
  end
  assign s1_data = err1_q ? '0 : rdata[bank1_q];
  assign bus.INIT_COUNT = count_q;
  assign bus.INIT_CSUM = csum_q;
  assign bus.BUSY = load;
  assign bus.INIT_DONE = state_q == DONE;
  if (PIPE != 0) begin : g_pipe
    logic v2_q, err2_q;
    always_ff @(posedge RWCLK) begin
      if (RESET) begin
        v2_q <= 1'b0;
        err2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        err2_q <= err1_q;
      end
    end
    assign bus.RD = hold_q;
    assign bus.RVALID = v2_q;
    assign bus.RERR = err2_q;
  end else begin : g_direct
    assign bus.RD = v1_q ? s1_data : hold_q;
    assign bus.RVALID = v1_q;
    assign bus.RERR = err1_q;
  end
endmodule

// File: tb/tb_iram_param_ctrl.sv
// tb_iram_param_ctrl: randomized self-checking bench over three RAM geometries against a behavioural model
module tb_iram_param_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int sel;
  logic s_start, s_valid, s_last, s_ren;
  logic [8:0] s_data;
  logic [11:0] s_raddr;
  logic [8:0] o_rd, o_csum;
  logic o_rvalid, o_rerr, o_ready, o_done, o_busy;
  logic [12:0] o_count;
  iram_param_ctrl_if #(.DATA_WIDTH(9), .DEPTH(512)) ia ();
  iram_param_ctrl_if #(.DATA_WIDTH(9), .DEPTH(1024)) ib ();
  iram_param_ctrl_if #(.DATA_WIDTH(9), .DEPTH(1536)) ic ();
  iram_param_ctrl #(.DATA_WIDTH(9), .DEPTH(512), .PIPE(0)) dut_a (.RWCLK(clk), .RESET(rst), .bus(ia));
  iram_param_ctrl #(.DATA_WIDTH(9), .DEPTH(1024), .PIPE(1)) dut_b (.RWCLK(clk), .RESET(rst), .bus(ib));
  iram_param_ctrl #(.DATA_WIDTH(9), .DEPTH(1536), .PIPE(0)) dut_c (.RWCLK(clk), .RESET(rst), .bus(ic));
  assign ia.RENABLE = s_ren && sel == 0;
  assign ib.RENABLE = s_ren && sel == 1;
  assign ic.RENABLE = s_ren && sel == 2;
  assign ia.RADDR = s_raddr[8:0];
  assign ib.RADDR = s_raddr[9:0];
  assign ic.RADDR = s_raddr[10:0];
  assign ia.INIT_START = s_start && sel == 0;
  assign ib.INIT_START = s_start && sel == 1;
  assign ic.INIT_START = s_start && sel == 2;
  assign ia.INIT_VALID = s_valid && sel == 0;
  assign ib.INIT_VALID = s_valid && sel == 1;
  assign ic.INIT_VALID = s_valid && sel == 2;
  assign ia.INIT_DATA = s_data;
  assign ib.INIT_DATA = s_data;
  assign ic.INIT_DATA = s_data;
  assign ia.INIT_LAST = s_last;
  assign ib.INIT_LAST = s_last;
  assign ic.INIT_LAST = s_last;
  assign o_rd = sel == 0 ? ia.RD : sel == 1 ? ib.RD : ic.RD;
  assign o_rvalid = sel == 0 ? ia.RVALID : sel == 1 ? ib.RVALID : ic.RVALID;
  assign o_rerr = sel == 0 ? ia.RERR : sel == 1 ? ib.RERR : ic.RERR;
  assign o_ready = sel == 0 ? ia.INIT_READY : sel == 1 ? ib.INIT_READY : ic.INIT_READY;
  assign o_done = sel == 0 ? ia.INIT_DONE : sel == 1 ? ib.INIT_DONE : ic.INIT_DONE;
  assign o_busy = sel == 0 ? ia.BUSY : sel == 1 ? ib.BUSY : ic.BUSY;
  assign o_csum = sel == 0 ? ia.INIT_CSUM : sel == 1 ? ib.INIT_CSUM : ic.INIT_CSUM;
  assign o_count = sel == 0 ? 13'(ia.INIT_COUNT) : sel == 1 ? 13'(ib.INIT_COUNT) : 13'(ic.INIT_COUNT);
  int dep [3] = '{512, 1024, 1536};
  int lat [3] = '{1, 2, 1};
  logic [8:0] mem [3][2048];
  bit m_load [3];
  bit m_done [3];
  int m_count [3];
  logic [8:0] m_csum [3];
  logic [8:0] m_rd [3];
  int n_chk = 0;
  int n_fail = 0;
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_load[k] = 0;
      m_done[k] = 0;
      m_count[k] = 0;
      m_csum[k] = '0;
      m_rd[k] = '0;
    end
  endtask
  task automatic idle();
    s_start = 0; s_valid = 0; s_last = 0; s_data = '0; s_ren = 0; s_raddr = '0;
  endtask
  task automatic load_cycle(input bit st, input bit v, input logic [8:0] d, input bit l);
    bit hs, exp_rdy;
    s_start = st; s_valid = v; s_data = d; s_last = l;
    #1;
    exp_rdy = m_load[sel] && !st;
    n_chk++;
    if (o_ready !== exp_rdy) begin n_fail++; $display("FAIL init_ready sel%0d: got %b exp %b", sel, o_ready, exp_rdy); end
    hs = v && exp_rdy;
    @(posedge clk); #1;
    if (st) begin
      m_load[sel] = 1; m_done[sel] = 0; m_count[sel] = 0; m_csum[sel] = '0;
    end else if (hs) begin
      mem[sel][m_count[sel]] = d;
      m_count[sel]++;
      m_csum[sel] ^= d;
      if (l || m_count[sel] == dep[sel]) begin m_load[sel] = 0; m_done[sel] = 1; end
    end
    n_chk++;
    if (o_count !== 13'(m_count[sel])) begin n_fail++; $display("FAIL init_count sel%0d: got %0d exp %0d", sel, o_count, m_count[sel]); end
    n_chk++;
    if (o_csum !== m_csum[sel]) begin n_fail++; $display("FAIL init_csum sel%0d: got %h exp %h", sel, o_csum, m_csum[sel]); end
    n_chk++;
    if (o_busy !== m_load[sel]) begin n_fail++; $display("FAIL busy sel%0d: got %b exp %b", sel, o_busy, m_load[sel]); end
    n_chk++;
    if (o_done !== m_done[sel]) begin n_fail++; $display("FAIL init_done sel%0d: got %b exp %b", sel, o_done, m_done[sel]); end
    n_chk++;
    if (o_rvalid !== 1'b0 || o_rd !== m_rd[sel]) begin
      n_fail++; $display("FAIL idle_read sel%0d: got rvalid %b rd %h exp 0 %h", sel, o_rvalid, o_rd, m_rd[sel]);
    end
  endtask
  task automatic do_reads(input int q[$]);
    int j;
    bit exp_v, exp_e;
    logic [8:0] exp_d;
    for (int k = 0; k < q.size() + lat[sel]; k++) begin
      s_ren = k < q.size();
      s_raddr = s_ren ? 12'(q[k]) : '0;
      @(posedge clk); #1;
      j = k - lat[sel] + 1;
      exp_v = j >= 0 && j < q.size();
      exp_e = 0;
      if (exp_v) begin
        exp_e = q[j] >= dep[sel];
        exp_d = exp_e ? 9'h000 : mem[sel][q[j]];
        m_rd[sel] = exp_d;
      end else exp_d = m_rd[sel];
      n_chk++;
      if (o_rvalid !== exp_v) begin n_fail++; $display("FAIL rvalid sel%0d k%0d: got %b exp %b", sel, k, o_rvalid, exp_v); end
      n_chk++;
      if (o_rerr !== exp_e) begin n_fail++; $display("FAIL rerr sel%0d k%0d: got %b exp %b", sel, k, o_rerr, exp_e); end
      n_chk++;
      if (o_rd !== exp_d) begin n_fail++; $display("FAIL rd sel%0d k%0d: got %h exp %h", sel, k, o_rd, exp_d); end
    end
    s_ren = 0;
  endtask
  task automatic test_reset();
    rst = 1; idle();
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      n_chk++;
      if ({o_rd, o_rvalid, o_rerr, o_ready, o_done, o_count, o_csum, o_busy} !== 36'h0) begin
        n_fail++; $display("FAIL reset_values sel%0d: got %h exp 0", k, {o_rd, o_rvalid, o_rerr, o_ready, o_done, o_count, o_csum, o_busy});
      end
    end
    rst = 0;
  endtask
  task automatic test_basic();
    int q[$];
    sel = 0;
    load_cycle(1, 0, 9'h000, 0);
    load_cycle(0, 1, 9'h1A5, 0);
    load_cycle(0, 1, 9'h0FF, 0);
    load_cycle(0, 1, 9'h100, 0);
    load_cycle(0, 1, 9'h003, 1);
    n_chk++;
    if ({o_done, o_count, o_csum} !== {1'b1, 13'd4, 9'h059}) begin
      n_fail++; $display("FAIL basic_load: got done %b count %0d csum %h exp 1 4 059", o_done, o_count, o_csum);
    end
    q.push_back(2);
    for (int k = 0; k < 6; k++) q.push_back(int'($urandom_range(0, 3)));
    do_reads(q);
  endtask
  task automatic test_full_load();
    int q[$];
    sel = 1;
    load_cycle(1, 0, 9'h000, 0);
    for (int i = 0; i < 1024; i++) load_cycle(0, 1, 9'(i), 0);
    n_chk++;
    if ({o_done, o_count} !== {1'b1, 13'd1024}) begin
      n_fail++; $display("FAIL full_load: got done %b count %0d exp 1 1024", o_done, o_count);
    end
    load_cycle(0, 1, 9'h1AB, 0);
    q.push_back(513);
    do_reads(q);
    q.delete();
    q.push_back(0); q.push_back(512); q.push_back(1023);
    for (int k = 0; k < 5; k++) q.push_back(int'($urandom_range(0, 1023)));
    do_reads(q);
  endtask
  task automatic test_valid_toggle();
    int q[$];
    sel = 2;
    load_cycle(1, 0, 9'h000, 0);
    for (int k = 0; k < 24; k++) load_cycle(0, k % 2 == 0, 9'($urandom), 0);
    load_cycle(0, 1, 9'($urandom), 1);
    n_chk++;
    if (o_count !== 13'd13) begin n_fail++; $display("FAIL toggle_count: got %0d exp 13", o_count); end
    for (int k = 0; k < 8; k++) q.push_back(int'($urandom_range(0, 12)));
    do_reads(q);
  endtask
  task automatic test_restart();
    int q[$];
    sel = 0;
    load_cycle(1, 0, 9'h000, 0);
    for (int k = 0; k < 5; k++) load_cycle(0, 1, 9'($urandom), 0);
    load_cycle(1, 1, 9'h1FF, 0);
    n_chk++;
    if ({o_count, o_csum} !== 22'h0) begin
      n_fail++; $display("FAIL restart_clear: got count %0d csum %h exp 0 0", o_count, o_csum);
    end
    load_cycle(0, 1, 9'h055, 1);
    q.push_back(0);
    for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 4)));
    do_reads(q);
  endtask
  task automatic test_read_in_load();
    int q[$];
    sel = 2;
    load_cycle(1, 0, 9'h000, 0);
    s_ren = 1;
    for (int k = 0; k < 6; k++) begin
      s_raddr = 12'($urandom_range(0, 2047));
      load_cycle(0, 1, 9'($urandom), k == 5);
    end
    s_ren = 0;
    q.push_back(1600); q.push_back(2); q.push_back(2047); q.push_back(5); q.push_back(1536); q.push_back(9);
    do_reads(q);
  endtask
  task automatic test_reset_mid();
    int q[$];
    sel = 1;
    load_cycle(1, 0, 9'h000, 0);
    for (int k = 0; k < 3; k++) load_cycle(0, 1, 9'($urandom), 0);
    rst = 1; idle();
    @(posedge clk); #1;
    model_reset();
    n_chk++;
    if ({o_rd, o_rvalid, o_rerr, o_ready, o_done, o_count, o_csum, o_busy} !== 36'h0) begin
      n_fail++; $display("FAIL reset_mid_load: got %h exp 0", {o_rd, o_rvalid, o_rerr, o_ready, o_done, o_count, o_csum, o_busy});
    end
    rst = 0;
    q.push_back(1);
    do_reads(q);
    s_ren = 1; s_raddr = 12'd2;
    @(posedge clk); #1;
    s_ren = 0; rst = 1;
    @(posedge clk); #1;
    model_reset();
    n_chk++;
    if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rvalid: got %b exp 0", o_rvalid); end
    rst = 0;
    @(posedge clk); #1;
    n_chk++;
    if ({o_rvalid, o_rd} !== 10'h0) begin n_fail++; $display("FAIL flush_late: got rvalid %b rd %h exp 0 000", o_rvalid, o_rd); end
  endtask
  initial begin
    idle();
    sel = 0;
    test_reset();
    test_basic();
    test_full_load();
    test_valid_toggle();
    test_restart();
    test_read_in_load();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 time units");
    $fatal(1);
  end
endmodule
